mem_arbiter: RTL and testbench

- Memory-side block directly downstream of the pipelined CPU core.
- Takes the core's per-cycle instruction fetch and data access requests and serialises them onto a single-port, variable-latency backing memory.
- Returns the instruction and load data to the core and drives the global `ready` that stalls every pipeline register.
- Replaces direct core-to-memory wiring with a sequenced FSM, latched request capture and a wait watchdog.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter_wait_timer.sv | 26 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DATA  = 2'b01,
    INSTR = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and backing-memory-side signals of the arbiter, grouped as one bus.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = mem_arbiter_pkg::DATA_W_DEF
);

  logic              i_fetch;
  logic [ADDR_W-1:0] i_addr;
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] wrt_data;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] rd_data;
  logic              ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              err;

  // The arbiter itself.
  modport master (
    input  i_fetch, i_addr, re, we, d_addr, wrt_data, mem_rdata, mem_valid,
    output instr, rd_data, ready, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  // Core plus backing memory, as seen from the other side.
  modport slave (
    output i_fetch, i_addr, re, we, d_addr, wrt_data, mem_rdata, mem_valid,
    input  instr, rd_data, ready, mem_req, mem_we, mem_addr, mem_wdata, err
  );

endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// Watchdog for one outstanding memory access; expired fires on the cycle
// the count would reach limit.
module wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  assign expired = tick && (count == limit - 8'd1);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core data and fetch requests onto a single-port, variable-latency
// memory; data access always precedes the fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.master bus
);

  state_t            state;
  logic              l_fetch;
  logic              l_we;
  logic [ADDR_W-1:0] l_i_addr;

  logic any_req;
  logic data_req;
  logic in_access;
  logic finish;
  logic expired;
  logic wt_clear;
  logic wt_tick;

  assign any_req   = bus.i_fetch | bus.re | bus.we;
  assign data_req  = bus.re | bus.we;
  assign in_access = (state == DATA) || (state == INSTR);
  assign finish    = bus.mem_valid || expired;
  assign wt_tick   = in_access && !bus.mem_valid;
  assign wt_clear  = !in_access || finish;

  assign bus.ready = !rst && ((state == DONE) || ((state == IDLE) && !any_req));

  wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wt_clear),
    .tick    (wt_tick),
    .limit   (8'(MAX_WAIT)),
    .expired (expired)
  );

  // d_addr and wrt_data are latched straight into mem_addr/mem_wdata, which
  // already hold them for the whole data access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      l_fetch       <= 1'b0;
      l_we          <= 1'b0;
      l_i_addr      <= '0;
      bus.instr     <= DATA_W'(NOP_INSTR);
      bus.rd_data   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            l_fetch       <= bus.i_fetch;
            l_we          <= bus.we;
            l_i_addr      <= bus.i_addr;
            bus.mem_req   <= 1'b1;
            bus.mem_wdata <= bus.wrt_data;
            if (data_req) begin
              bus.mem_we   <= bus.we;
              bus.mem_addr <= bus.d_addr;
              state        <= DATA;
            end else begin
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.i_addr;
              state        <= INSTR;
            end
          end
        end
        DATA: begin
          if (finish) begin
            if (!l_we) begin
              bus.rd_data <= bus.mem_valid ? bus.mem_rdata : '0;
            end
            if (expired) begin
              bus.err <= 1'b1;
            end
            bus.mem_we <= 1'b0;
            if (l_fetch) begin
              bus.mem_addr <= l_i_addr;
              state        <= INSTR;
            end else begin
              bus.mem_req <= 1'b0;
              state       <= DONE;
            end
          end
        end
        INSTR: begin
          if (finish) begin
            bus.instr <= bus.mem_valid ? bus.mem_rdata : DATA_W'(NOP_INSTR);
            if (expired) begin
              bus.err <= 1'b1;
            end
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions against a
// latency-programmable memory model.
module tb_mem_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned MAXW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: each access completes after 'lat' wait cycles.
  logic [15:0] mem [logic [15:0]];
  int unsigned lat_q[$];
  logic [16:0] obs[$];
  logic        active = 1'b0;
  int unsigned waited = 0;
  int unsigned lat    = 0;
  logic [16:0] prev_id = '0;

  always @(negedge clk) begin
    if (rst || !bus.mem_req) begin
      active        = 1'b0;
      bus.mem_valid = 1'b0;
    end else begin
      if (!active || bus.mem_valid || ({bus.mem_we, bus.mem_addr} != prev_id)) begin
        active = 1'b1;
        waited = 0;
        if (lat_q.size() > 0) lat = lat_q.pop_front();
        else lat = 0;
        obs.push_back({bus.mem_we, bus.mem_addr});
      end else begin
        waited++;
      end
      prev_id = {bus.mem_we, bus.mem_addr};
      if (waited == lat) begin
        bus.mem_valid = 1'b1;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        if (mem.exists(bus.mem_addr)) bus.mem_rdata = mem[bus.mem_addr];
        else bus.mem_rdata = 16'h0000;
      end else begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 16'hDEAD;
      end
    end
  end

  typedef struct {
    int unsigned start;
    int unsigned cycle;
    logic [15:0] instr;
    logic [15:0] rd;
    logic        err;
    int unsigned n_acc;
    logic [16:0] acc0;
    logic [16:0] acc1;
    logic        early;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: ready must stay low while stalled, then present the expected result.
  always @(negedge clk) begin
    #2;
    if (!rst && sb.size() > 0) begin
      if (cyc >= sb[0].start && cyc < sb[0].cycle && bus.ready) sb[0].early = 1'b1;
      if (cyc == sb[0].cycle) begin
        mon_e = sb.pop_front();
        chk("stall_ready", {31'd0, mon_e.early}, 32'd0);
        chk("ready", {31'd0, bus.ready}, 32'd1);
        chk("instr", {16'd0, bus.instr}, {16'd0, mon_e.instr});
        chk("rd_data", {16'd0, bus.rd_data}, {16'd0, mon_e.rd});
        chk("err", {31'd0, bus.err}, {31'd0, mon_e.err});
        chk("mem_req_done", {31'd0, bus.mem_req}, 32'd0);
        chk("acc_count", obs.size(), mon_e.n_acc);
        if (obs.size() > 0) chk("acc0", {15'd0, obs[0]}, {15'd0, mon_e.acc0});
        if (obs.size() > 1) chk("acc1", {15'd0, obs[1]}, {15'd0, mon_e.acc1});
        obs.delete();
      end
    end
  end

  task automatic clear_inputs();
    bus.i_fetch  = 1'b0;
    bus.i_addr   = '0;
    bus.re       = 1'b0;
    bus.we       = 1'b0;
    bus.d_addr   = '0;
    bus.wrt_data = '0;
  endtask

  task automatic issue(input logic f, input logic [15:0] ia, input logic r, input logic w,
                       input logic [15:0] da, input logic [15:0] wd, input int unsigned done_lat,
                       input logic [15:0] e_instr, input logic [15:0] e_rd, input logic e_err,
                       input int unsigned n_acc, input logic [16:0] a0, input logic [16:0] a1);
    exp_t e;
    @(negedge clk);
    bus.i_fetch  = f;
    bus.i_addr   = ia;
    bus.re       = r;
    bus.we       = w;
    bus.d_addr   = da;
    bus.wrt_data = wd;
    e.start = cyc;
    e.cycle = cyc + done_lat;
    e.instr = e_instr;
    e.rd    = e_rd;
    e.err   = e_err;
    e.n_acc = n_acc;
    e.acc0  = a0;
    e.acc1  = a1;
    e.early = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    clear_inputs();
    while (cyc <= e.cycle) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 16'h0000;
    mem[16'h0010] = 16'hB123;
    mem[16'h0040] = 16'h00AA;
    mem[16'h0011] = 16'h8001;
    mem[16'h0012] = 16'h4321;

    #12;
    chk("rst_instr", {16'd0, bus.instr}, 32'h0000);
    chk("rst_rd_data", {16'd0, bus.rd_data}, 32'h0000);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch only, latency 3: ready 5 cycles after the request.
    lat_q.push_back(3);
    issue(1, 16'h0010, 0, 0, 16'h0, 16'h0, 5, 16'hB123, 16'h0000, 0, 1, {1'b0, 16'h0010}, '0);

    // Load (latency 1) then fetch (latency 2).
    lat_q.push_back(1); lat_q.push_back(2);
    issue(1, 16'h0011, 1, 0, 16'h0040, 16'h0, 6, 16'h8001, 16'h00AA, 0, 2,
          {1'b0, 16'h0040}, {1'b0, 16'h0011});

    // Store then fetch of the same address, both same-cycle completion.
    lat_q.push_back(0); lat_q.push_back(0);
    issue(1, 16'h0011, 0, 1, 16'h0011, 16'h9ABC, 3, 16'h9ABC, 16'h00AA, 0, 2,
          {1'b1, 16'h0011}, {1'b0, 16'h0011});

    // No request: ready in the same cycle, no memory traffic.
    issue(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h9ABC, 16'h00AA, 0, 0, '0, '0);

    // Load never completes: timeout after MAX_WAIT cycles, fetch still done.
    lat_q.push_back(255); lat_q.push_back(1);
    issue(1, 16'h0012, 1, 0, 16'h0050, 16'h0, 11, 16'h4321, 16'h0000, 1, 2,
          {1'b0, 16'h0050}, {1'b0, 16'h0012});

    // err stays sticky on a later normal fetch.
    lat_q.push_back(2);
    issue(1, 16'h0010, 0, 0, 16'h0, 16'h0, 4, 16'hB123, 16'h0000, 1, 1, {1'b0, 16'h0010}, '0);

    // Reset pulsed while the fetch is waiting in INSTR.
    lat_q.push_back(6);
    @(negedge clk);
    bus.i_fetch = 1'b1;
    bus.i_addr  = 16'h0012;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_instr", {16'd0, bus.instr}, 32'h0000);
    chk("arst_rd_data", {16'd0, bus.rd_data}, 32'h0000);
    chk("arst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("arst_ready", {31'd0, bus.ready}, 32'd0);
    chk("arst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat_q.delete();
    obs.delete();

    // Fetch after reset completes normally and sees the earlier store.
    lat_q.push_back(1);
    issue(1, 16'h0011, 0, 0, 16'h0, 16'h0, 3, 16'h9ABC, 16'h0000, 0, 1, {1'b0, 16'h0011}, '0);

    // Load only with same-cycle completion: minimum 2-cycle latency.
    lat_q.push_back(0);
    issue(0, 16'h0, 1, 0, 16'h0040, 16'h0, 2, 16'h9ABC, 16'h00AA, 0, 1, {1'b0, 16'h0040}, '0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
